// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between ALU (req0) and load (req1) writeback, plus a busy scoreboard
// Ports: req0_*/req1_* valid/ready writeback requests; wb_hold blocks grants; busy_set/busy_set_addr mark a register pending;
//        rf_write_enable/rf_write_reg/rf_data_in registered reg-file write port; busy_vec pending bits; wr_count saturating write count.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  wb_hold,
  input  logic                  busy_set,
  input  logic [ADDR_WIDTH-1:0] busy_set_addr,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_reg,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [CNT_WIDTH-1:0]  wr_count
);
  logic                  last_grant;
  logic                  xfer;
  logic                  real_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   busy_nxt;
  // last_grant=1 means req1 was served last, so req0 wins the next contention
  assign req0_ready = rst_n && !wb_hold && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = rst_n && !wb_hold && req1_valid && (!req0_valid || !last_grant);
  assign xfer = req0_ready || req1_ready;
  assign sel_addr = req1_ready ? req1_addr : req0_addr;
  assign sel_data = req1_ready ? req1_data : req0_data;
  assign real_wr = xfer && sel_addr != '0;
  // clear for the write retiring this cycle first, so a same-cycle set on that register wins
  always_comb begin
    busy_nxt = busy_vec;
    if (rf_write_enable) busy_nxt[rf_write_reg] = 1'b0;
    if (busy_set) busy_nxt[busy_set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      rf_write_enable <= 1'b0;
      rf_write_reg <= '0;
      rf_data_in <= '0;
      busy_vec <= '0;
      wr_count <= '0;
    end else begin
      if (xfer) last_grant <= req1_ready;
      rf_write_enable <= real_wr;
      if (real_wr) begin
        rf_write_reg <= sel_addr;
        rf_data_in <= sel_data;
      end
      busy_vec <= busy_nxt;
      if (rf_write_enable && !(&wr_count)) wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0, wb_hold = 0, busy_set = 0;
  logic [4:0]  req0_addr = 0, req1_addr = 0, busy_set_addr = 0;
  logic [31:0] req0_data = 0, req1_data = 0;
  logic        req0_ready, req1_ready, rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_data_in, busy_vec;
  logic [15:0] wr_count;
  int          checks = 0, passes = 0;
  logic [15:0] exp_cnt = 0;
  logic [36:0] sb[$];
  logic [36:0] e;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wb_hold(wb_hold), .busy_set(busy_set), .busy_set_addr(busy_set_addr),
    .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg), .rf_data_in(rf_data_in),
    .busy_vec(busy_vec), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // drive one cycle of requests, check grants, then check the output stage after the edge
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic r0, input logic r1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(r0));
    chk("req1_ready", 32'(req1_ready), 32'(r1));
    if (r0 && a0 != 0) sb.push_back({a0, d0});
    if (r1 && a1 != 0) sb.push_back({a1, d1});
    @(posedge clk);
    #1;
    chk("wr_count", 32'(wr_count), 32'(exp_cnt));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      exp_cnt++;
      chk("we", 32'(rf_write_enable), 32'd1);
      chk("write_reg", 32'(rf_write_reg), 32'(e[36:32]));
      chk("data_in", rf_data_in, e[31:0]);
    end else chk("we_idle", 32'(rf_write_enable), 32'd0);
  endtask

  initial begin
    req0_valid = 1;
    #3;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_we", 32'(rf_write_enable), 32'd0);
    chk("rst_reg", 32'(rf_write_reg), 32'd0);
    chk("rst_data", rf_data_in, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_cnt", 32'(wr_count), 32'd0);
    @(posedge clk); #1 rst_n = 1;
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 0);
    // register 0 discard; also makes req1 the last grant
    step(0, 0, 0, 1, 5'd0, 32'h12345678, 0, 1);
    chk("x0_busy", busy_vec, 32'd0);
    // contention: requester holds its request until served
    step(1, 5'd1, 32'hA1, 1, 5'd11, 32'hB1, 1, 0);
    step(1, 5'd2, 32'hA2, 1, 5'd11, 32'hB1, 0, 1);
    step(1, 5'd2, 32'hA2, 1, 5'd12, 32'hB2, 1, 0);
    step(1, 5'd3, 32'hA3, 1, 5'd12, 32'hB2, 0, 1);
    // scoreboard set / clear / set-wins
    busy_set = 1; busy_set_addr = 7;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    busy_set = 0;
    chk("busy_set7", busy_vec, 32'h80);
    step(1, 5'd7, 32'h77, 0, 0, 0, 1, 0);
    chk("busy_held", busy_vec, 32'h80);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("busy_clr7", busy_vec, 32'h0);
    step(1, 5'd7, 32'h78, 0, 0, 0, 1, 0);
    busy_set = 1; busy_set_addr = 7;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("busy_setwins", busy_vec, 32'h80);
    busy_set_addr = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    busy_set = 0;
    chk("busy_x0", busy_vec, 32'h80);
    // hold: last grant was req0, so req1 goes first after release
    wb_hold = 1;
    for (int i = 0; i < 3; i++) step(1, 5'd20, 32'hC0, 1, 5'd21, 32'hD0, 0, 0);
    wb_hold = 0;
    step(1, 5'd20, 32'hC0, 1, 5'd21, 32'hD0, 0, 1);
    step(1, 5'd20, 32'hC0, 0, 0, 0, 1, 0);
    // async reset while a write is in the output stage
    busy_set = 1; busy_set_addr = 3;
    step(1, 5'd9, 32'h99, 0, 0, 0, 1, 0);
    busy_set = 0; req0_valid = 0;
    chk("pre_busy", busy_vec, 32'h88);
    #2 rst_n = 0;
    #1;
    chk("arst_we", 32'(rf_write_enable), 32'd0);
    chk("arst_reg", 32'(rf_write_reg), 32'd0);
    chk("arst_data", rf_data_in, 32'd0);
    chk("arst_busy", busy_vec, 32'd0);
    chk("arst_cnt", 32'(wr_count), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
